// File: rtl/game_pkg.sv
// Shared types for the game screen controller: FSM states and the one-hot
// screen-enable bundle decoded from them.
package game_pkg;

    typedef enum logic [1:0] {
        MENU      = 2'd0,
        GAME      = 2'd1,
        LEVEL_UP  = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    typedef struct packed {
        logic menu;
        logic game;
        logic levelup;
        logic over;
    } screen_en_t;

    function automatic screen_en_t decode_screen(input game_state_t st);
        screen_en_t en;
        en = '0;
        case (st)
            MENU:      en.menu    = 1'b1;
            GAME:      en.game    = 1'b1;
            LEVEL_UP:  en.levelup = 1'b1;
            GAME_OVER: en.over    = 1'b1;
            default:   en.menu    = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the video/game logic side (master) and game_ctrl (slave).
interface game_ctrl_if;
    logic       vsync;
    logic       btn_start;
    logic       player_dead;
    logic       level_done;
    logic       menu_en;
    logic       game_en;
    logic       levelup_en;
    logic       over_en;
    logic [1:0] level;
    logic       frame_start;

    modport master (
        output vsync, btn_start, player_dead, level_done,
        input  menu_en, game_en, levelup_en, over_en, level, frame_start
    );

    modport slave (
        input  vsync, btn_start, player_dead, level_done,
        output menu_en, game_en, levelup_en, over_en, level, frame_start
    );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge
// detector producing a single-cycle pulse.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);
    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn_in};
            prev_reg <= sync_reg[1];
        end
    end

    assign pulse = sync_reg[1] & ~prev_reg;
endmodule

// File: rtl/game_ctrl.sv
// Screen-level game FSM: events are latched as pending and only committed on
// a frame boundary so the displayed screen never changes mid-frame.
module game_ctrl
    import game_pkg::*;
#(
    parameter int OVER_FRAMES    = 180,
    parameter int LEVELUP_FRAMES = 60,
    parameter int NUM_LEVELS     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    game_ctrl_if.slave  bus
);
    localparam int MAX_FRAMES = (OVER_FRAMES > LEVELUP_FRAMES) ? OVER_FRAMES : LEVELUP_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] LEVELUP_LAST = CNT_W'(LEVELUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST    = CNT_W'(OVER_FRAMES - 1);
    localparam logic [1:0]       LAST_LEVEL   = 2'(NUM_LEVELS - 1);

    logic             start_pulse;
    logic             vsync_prev_reg;
    logic             frame_start_reg;
    game_state_t      state_reg, state_next;
    screen_en_t       en_reg;
    logic [1:0]       level_reg, level_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pend_start_reg, pend_start_next;
    logic             pend_dead_reg, pend_dead_next;
    logic             pend_done_reg, pend_done_next;

    btn_sync u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (bus.btn_start),
        .pulse  (start_pulse)
    );

    always_comb begin
        state_next      = state_reg;
        level_next      = level_reg;
        cnt_next        = cnt_reg;
        pend_start_next = pend_start_reg | (start_pulse      & (state_reg == MENU));
        pend_dead_next  = pend_dead_reg  | (bus.player_dead  & (state_reg == GAME));
        pend_done_next  = pend_done_reg  | (bus.level_done   & (state_reg == GAME));

        if (frame_start_reg) begin
            case (state_reg)
                MENU: begin
                    if (pend_start_reg) begin
                        state_next = GAME;
                        level_next = 2'd0;
                    end
                end
                GAME: begin
                    if (pend_dead_reg) begin
                        state_next = GAME_OVER;
                    end else if (pend_done_reg) begin
                        if (level_reg < LAST_LEVEL) begin
                            state_next = LEVEL_UP;
                            level_next = level_reg + 2'd1;
                        end else begin
                            state_next = GAME_OVER;
                        end
                    end
                end
                LEVEL_UP: begin
                    if (cnt_reg >= LEVELUP_LAST) state_next = GAME;
                    else                         cnt_next   = cnt_reg + 1'b1;
                end
                GAME_OVER: begin
                    if (cnt_reg >= OVER_LAST) begin
                        state_next = MENU;
                        level_next = 2'd0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = MENU;
            endcase
        end

        // A commit discards everything, including an event sampled in the commit cycle.
        if (state_next != state_reg) begin
            cnt_next        = '0;
            pend_start_next = 1'b0;
            pend_dead_next  = 1'b0;
            pend_done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            state_reg       <= MENU;
            en_reg          <= decode_screen(MENU);
            level_reg       <= 2'd0;
            cnt_reg         <= '0;
            pend_start_reg  <= 1'b0;
            pend_dead_reg   <= 1'b0;
            pend_done_reg   <= 1'b0;
        end else begin
            vsync_prev_reg  <= bus.vsync;
            frame_start_reg <= bus.vsync & ~vsync_prev_reg;
            state_reg       <= state_next;
            en_reg          <= decode_screen(state_next);
            level_reg       <= level_next;
            cnt_reg         <= cnt_next;
            pend_start_reg  <= pend_start_next;
            pend_dead_reg   <= pend_dead_next;
            pend_done_reg   <= pend_done_next;
        end
    end

    assign bus.menu_en     = en_reg.menu;
    assign bus.game_en     = en_reg.game;
    assign bus.levelup_en  = en_reg.levelup;
    assign bus.over_en     = en_reg.over;
    assign bus.level       = level_reg;
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_game_ctrl.sv
// Frame-level reference model of the game screen controller, driven with
// directed scenarios followed by randomized frames; one line per frame.
module tb_game_ctrl;
    localparam int FL = 32;
    localparam int LU = 60;
    localparam int OV = 180;
    localparam int NL = 3;

    localparam int M_MENU = 0;
    localparam int M_GAME = 1;
    localparam int M_LVL  = 2;
    localparam int M_OVER = 3;

    localparam int EV_START = 0;
    localparam int EV_DEAD  = 1;
    localparam int EV_DONE  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_ctrl_if bus();

    game_ctrl #(
        .OVER_FRAMES    (OV),
        .LEVELUP_FRAMES (LU),
        .NUM_LEVELS     (NL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int frame_no = 0;

    int m_mode, m_level, m_frames;
    bit p_start, p_dead, p_done;
    bit l_dead, l_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
        end
    endtask

    function automatic logic [3:0] exp_en(input int mode);
        logic [3:0] v;
        v = 4'b1000 >> mode;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_MENU; m_level = 0; m_frames = 0;
        p_start = 0; p_dead = 0; p_done = 0; l_dead = 0; l_done = 0;
    endtask

    // Frame-boundary rules of the game screens.
    task automatic model_commit();
        int new_mode;
        int new_level;
        new_mode  = m_mode;
        new_level = m_level;
        if (m_mode == M_MENU) begin
            if (p_start) begin new_mode = M_GAME; new_level = 0; end
        end else if (m_mode == M_GAME) begin
            if (p_dead) new_mode = M_OVER;
            else if (p_done) begin
                if (m_level < NL - 1) begin new_mode = M_LVL; new_level = m_level + 1; end
                else new_mode = M_OVER;
            end
        end else if (m_mode == M_LVL) begin
            m_frames++;
            if (m_frames == LU) new_mode = M_GAME;
        end else begin
            m_frames++;
            if (m_frames == OV) begin new_mode = M_MENU; new_level = 0; end
        end
        if (new_mode != m_mode) begin
            m_frames = 0;
            p_start = 0; p_dead = 0; p_done = 0; l_dead = 0; l_done = 0;
        end else begin
            p_dead = p_dead | l_dead;
            p_done = p_done | l_done;
            l_dead = 0; l_done = 0;
        end
        m_mode  = new_mode;
        m_level = new_level;
    endtask

    // c==1 is the frame_start cycle: such events only count for the following frame.
    task automatic model_event(input int kind, input int c);
        bit rel;
        rel = (kind == EV_START) ? (m_mode == M_MENU) : (m_mode == M_GAME);
        if (rel) begin
            if (kind == EV_START)     p_start = 1;
            else if (c == 1) begin
                if (kind == EV_DEAD) l_dead = 1; else l_done = 1;
            end else begin
                if (kind == EV_DEAD) p_dead = 1; else p_done = 1;
            end
        end
    endtask

    task automatic sample(input int c);
        logic [3:0] en;
        en = {bus.menu_en, bus.game_en, bus.levelup_en, bus.over_en};
        chk("enables", 32'(en), 32'(exp_en(m_mode)));
        chk("onehot", 32'($onehot(en)), 32'd1);
        chk("level", 32'(bus.level), 32'(m_level));
        chk("frame_start", 32'(bus.frame_start), 32'(c == 1));
    endtask

    task automatic run_frame(input int dead_at, input int done_at, input int btn_at, input int rst_at);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            if (c == 2) model_commit();
            sample(c);
            bus.vsync       = (c < 4);
            bus.player_dead = (c == dead_at);
            bus.level_done  = (c == done_at);
            if (c == dead_at) model_event(EV_DEAD, c);
            if (c == done_at) model_event(EV_DONE, c);
            if (c == btn_at) begin
                bus.btn_start = 1'b1;
                model_event(EV_START, c);
            end
            if (c == btn_at + 12 || c == FL - 1) bus.btn_start = 1'b0;
            if (rst_at >= 0 && c == rst_at) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                sample(c);
            end
            if (rst_at >= 0 && c == rst_at + 3) rst_n = 1'b1;
        end
        $display("frame %0d: mode=%0d level=%0d frames=%0d dead@%0d done@%0d btn@%0d rst@%0d",
                 frame_no, m_mode, m_level, m_frames, dead_at, done_at, btn_at, rst_at);
        frame_no++;
    endtask

    initial begin
        int d, l, b, r;
        bus.vsync = 1'b0; bus.btn_start = 1'b0;
        bus.player_dead = 1'b0; bus.level_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        sample(-1);
        rst_n = 1'b1;

        // Events in MENU are ignored; a mid-frame press starts the game at the next frame.
        run_frame(10, 15, -1, -1);
        run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, 9, -1);
        run_frame(-1, -1, -1, -1);

        // Death and level completion together: death wins, level unchanged; start ignored in GAME_OVER.
        run_frame(12, 12, 7, -1);
        for (int i = 0; i < OV + 4; i++) run_frame(-1, -1, (i == 5 || i == 100) ? 10 : -1, -1);

        // Walk through all levels, ending in GAME_OVER and back to MENU.
        run_frame(-1, -1, 6, -1);
        run_frame(-1, -1, -1, -1);
        for (int lv = 0; lv < NL; lv++) begin
            run_frame(-1, 20, -1, -1);
            for (int i = 0; i < LU + 2; i++) run_frame(-1, -1, -1, -1);
        end
        for (int i = 0; i < OV - LU + 2; i++) run_frame(-1, -1, -1, -1);

        // Event in the frame_start cycle is carried to the next boundary; reset at LEVEL_UP frame 30.
        run_frame(-1, -1, 8, -1);
        run_frame(-1, -1, -1, -1);
        run_frame(-1, 1, -1, -1);
        for (int i = 0; i < 30; i++) run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, -1, 14);
        run_frame(-1, -1, -1, -1);

        for (int i = 0; i < 300; i++) begin
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, FL - 8)) : -1;
            r = ($urandom_range(0, 79) == 0) ? int'($urandom_range(8, FL - 6)) : -1;
            if (r >= 0) begin d = -1; l = -1; b = -1; end
            run_frame(d, l, b, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
